// File: rtl/clk_set_ctrl_if.sv
// Button/strobe bundle for the clock time-setting controller.
// master drives the raw buttons, slave emits the counter strobes and mode.
interface clk_set_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       hrs_incr;
  logic       hrs_dcr;
  logic       min_incr;
  logic       min_dcr;
  logic       run_en;
  logic       sec_clr;
  logic [1:0] mode;

  modport master (
    output btn_mode, btn_up, btn_down,
    input  hrs_incr, hrs_dcr, min_incr, min_dcr,
    input  run_en, sec_clr, mode
  );

  modport slave (
    input  btn_mode, btn_up, btn_down,
    output hrs_incr, hrs_dcr, min_incr, min_dcr,
    output run_en, sec_clr, mode
  );
endinterface

// File: rtl/clk_set_ctrl.sv
// Time-setting front end: sync + debounce of mode/up/down buttons,
// RUN/SET_HRS/SET_MIN mode FSM, and incr/dcr pulses with auto-repeat.
// Ports: clk, rst_n (sync, active low), bus (slave: buttons in,
// hrs/min incr/dcr, run_en, sec_clr, mode out).
module clk_set_ctrl #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned RPT_CYCLES  = 4
) (
  input logic           clk,
  input logic           rst_n,
  clk_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HRS = 2'b01,
    SET_MIN = 2'b10,
    BAD     = 2'b11
  } mode_e;

  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
  localparam logic [15:0] HOLD_N   = 16'(HOLD_CYCLES);
  localparam logic [15:0] RPT_N    = 16'(RPT_CYCLES);

  // bit 0 = mode, bit 1 = up, bit 2 = down
  logic [2:0]  raw;
  logic [2:0]  s1_q, s2_q;
  logic [2:0]  deb_q, deb_d;
  logic [2:0]  prv_q;
  logic [15:0] dcnt_q [3];
  logic [15:0] dcnt_d [3];

  mode_e       mode_q, mode_d;
  logic        lk_up_q, lk_up_d;
  logic        lk_dn_q, lk_dn_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic        rph_q, rph_d;
  logic        hi_q, hi_d, hd_q, hd_d;
  logic        mi_q, mi_d, md_q, md_d;
  logic        sc_q, sc_d;

  logic [2:0]  rise;
  logic        mode_rise, both, set_mode;
  logic        en_up, en_dn, active;
  logic        new_press, hit, fire;

  assign raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) deb_d[i] = s2_q[i];
        else dcnt_d[i] = dcnt_q[i] + 16'd1;
      end
    end
  end

  assign rise      = deb_q & ~prv_q;
  assign mode_rise = rise[0];
  assign both      = deb_q[1] & deb_q[2];
  assign set_mode  = (mode_q == SET_HRS) || (mode_q == SET_MIN);

  // A button only drives pulses when it alone is held, it was pressed
  // fresh in a set mode, and no mode change is happening this cycle.
  assign en_up = deb_q[1] & ~deb_q[2] & ~lk_up_q
               & set_mode & ~mode_rise;
  assign en_dn = deb_q[2] & ~deb_q[1] & ~lk_dn_q
               & set_mode & ~mode_rise;
  assign active    = en_up | en_dn;
  assign new_press = (en_up & rise[1]) | (en_dn & rise[2]);
  assign hit       = rph_q ? (rcnt_q == RPT_N)
                           : (rcnt_q == HOLD_N);
  assign fire      = active & (new_press | hit);

  always_comb begin
    mode_d  = mode_q;
    lk_up_d = deb_q[1] & (lk_up_q | mode_rise | both);
    lk_dn_d = deb_q[2] & (lk_dn_q | mode_rise | both);
    rcnt_d  = '0;
    rph_d   = 1'b0;
    hi_d    = fire & en_up & (mode_q == SET_HRS);
    hd_d    = fire & en_dn & (mode_q == SET_HRS);
    mi_d    = fire & en_up & (mode_q == SET_MIN);
    md_d    = fire & en_dn & (mode_q == SET_MIN);
    sc_d    = mode_rise & (mode_q == SET_MIN);

    unique case (mode_q)
      RUN:     if (mode_rise) mode_d = SET_HRS;
      SET_HRS: if (mode_rise) mode_d = SET_MIN;
      SET_MIN: if (mode_rise) mode_d = RUN;
      BAD:     mode_d = RUN;
    endcase

    // Count stays one ahead: the pulse cycle loads 1, so the next
    // pulse lands exactly HOLD (then RPT) edges later.
    if (active) begin
      if (new_press) begin
        rcnt_d = 16'd1;
      end else if (hit) begin
        rcnt_d = 16'd1;
        rph_d  = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 16'd1;
        rph_d  = rph_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      prv_q   <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
      mode_q  <= RUN;
      lk_up_q <= 1'b0;
      lk_dn_q <= 1'b0;
      rcnt_q  <= '0;
      rph_q   <= 1'b0;
      hi_q    <= 1'b0;
      hd_q    <= 1'b0;
      mi_q    <= 1'b0;
      md_q    <= 1'b0;
      sc_q    <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      prv_q   <= deb_q;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
      mode_q  <= mode_d;
      lk_up_q <= lk_up_d;
      lk_dn_q <= lk_dn_d;
      rcnt_q  <= rcnt_d;
      rph_q   <= rph_d;
      hi_q    <= hi_d;
      hd_q    <= hd_d;
      mi_q    <= mi_d;
      md_q    <= md_d;
      sc_q    <= sc_d;
    end
  end

  assign bus.hrs_incr = hi_q;
  assign bus.hrs_dcr  = hd_q;
  assign bus.min_incr = mi_q;
  assign bus.min_dcr  = md_q;
  assign bus.sec_clr  = sc_q;
  assign bus.run_en   = (mode_q == RUN);
  assign bus.mode     = mode_q;

endmodule

// File: doc/clk_set_ctrl.md
Name: clk_set_ctrl

Overview:
- Front-end controller for the digital clock's time-setting buttons.
- Drives the incr/dcr inputs of the hours and minutes counters.
- Synchronises and debounces three raw push-buttons and runs a mode FSM (RUN / SET_HRS / SET_MIN).
- Emits single-cycle increment/decrement pulses with hold-to-auto-repeat, plus the run enable and the seconds-clear strobe for the timekeeping chain.

Parameters:
- DEB_CYCLES, 4: consecutive cycles a synchronised input must differ from its debounced level before the debounced level flips. Range 1..65535.
- HOLD_CYCLES, 16: cycles from the first press pulse to the first auto-repeat pulse. Range 2..65535.
- RPT_CYCLES, 4: cycles between auto-repeat pulses after the first repeat. Range 1..65535.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- btn_mode  in  1  raw mode button, active high, asynchronous to clk.
- btn_up  in  1  raw up button, active high, asynchronous.
- btn_down  in  1  raw down button, active high, asynchronous.
- hrs_incr  out  1  one-cycle increment pulse to the hours counter.
- hrs_dcr  out  1  one-cycle decrement pulse to the hours counter.
- min_incr  out  1  one-cycle increment pulse to the minutes counter.
- min_dcr  out  1  one-cycle decrement pulse to the minutes counter.
- run_en  out  1  high when the clock may advance (RUN mode).
- sec_clr  out  1  one-cycle pulse that clears the seconds counter.
- mode  out  2  00 = RUN, 01 = SET_HRS, 10 = SET_MIN; 11 unused.

Behaviour:
- Reset:
  - Applied when rst_n is low at a clk edge.
  - mode = 00 and run_en = 1.
  - All pulse outputs = 0.
  - Synchronisers, debounced levels, debounce counters and repeat counters are cleared; reset mid-press discards the press.
- Synchroniser: two flops per button.
- Debounce, per button:
  - At each edge, if the synced level differs from the debounced level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEB_CYCLES, the debounced level takes the synced level and the counter clears.
- Latency: with the raw input sampled high at edge 1, the debounced level rises at edge DEB_CYCLES+2 and the resulting output pulse is high after edge DEB_CYCLES+3.
- Mode FSM, advanced by the registered rising edge of debounced mode: RUN -> SET_HRS -> SET_MIN -> RUN.
  - mode reaches 11 only by fault; it returns to RUN on the next edge.
- run_en = 1 only in RUN.
- sec_clr pulses for one cycle on the same edge as the SET_MIN -> RUN transition, and never otherwise.
- Up/down pulses, in SET_HRS or SET_MIN only, routed to the selected field:
  - A debounced rising edge of up gives an incr pulse; of down, a dcr pulse.
  - Held: a second pulse comes HOLD_CYCLES cycles after the first, then one every RPT_CYCLES cycles while held.
  - On release (debounced low), pulses stop and the repeat counter clears.
- In RUN, up/down produce no pulses.
- Up and down both debounced high: no pulses, repeat counters held clear. Pulses resume only on a fresh rising edge after both are released.
- Mode edge while up/down is held:
  - The mode changes.
  - The held button is locked out, with no pulses, until it is released.
  - No pulse is issued on the mode-change edge.
- Invariant: at most one of hrs_incr, hrs_dcr, min_incr, min_dcr is high in any cycle. No output is ever high for two consecutive cycles, except with RPT_CYCLES = 1.

Test Plan:
- Reset with rst_n=0 for 2 cycles while buttons are idle -> mode=00, run_en=1, all pulses 0. Assert rst_n=0 mid-press -> outputs return to reset values at that edge.
- Debounce (DEB_CYCLES=4): btn_mode high for 3 cycles, then a 1-cycle bounce low, then high steadily -> no mode change until 4 stable cycles. mode=01, run_en=0 after edge 7, counted from the first stable-high sample.
- SET_HRS with btn_up held for 40 cycles -> hrs_incr pulses at relative cycles 0, 16, 20, 24, 28, 32, 36, 40-window; min_* stay 0. On release, no further pulses.
- Press mode twice more -> mode 10 then 00. sec_clr=1 for exactly one cycle on the 10->00 edge; run_en returns to 1.
- SET_MIN with btn_up and btn_down both held -> zero pulses. Release both, then press down once -> exactly one min_dcr pulse.
- RUN with btn_up tapped -> no pulses. Hold up, then press mode -> mode=01 with no hrs_incr until up is released and pressed again.
